// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the default load address.
// Defining LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StWrite   = 3'd2,
        StDone    = 3'd3
`ifdef LOADER_CHECKSUM_EN
        ,
        StCheck   = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles a stream of bytes into little-endian words: first byte lands in bits [7:0].
// full_o flags the accept that completes the word.
module byte_packer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  full_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    logic [IdxW-1:0]       idx_q;
    logic [DATA_WIDTH-1:0] word_q;

    assign full_o = accept_i && (idx_q == LastIdx);
    assign word_o = word_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (accept_i) begin
            word_q[8*idx_q +: 8] <= byte_i;
            idx_q                <= full_o ? '0 : idx_q + IdxW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams program bytes into instruction memory as little-endian words while holding the core.
// Optional LOADER_CHECKSUM_EN appends a mod-256 checksum byte verified after the last word.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [15:0]           word_count_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    state_e                state_q, state_d;
    logic [15:0]           remaining_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic                  error_q;

    logic   start_ok;
    logic   count_over;
    logic   pack_accept;
    logic   pack_full;
    state_e launch_state;

    // start is only honoured when not busy
    assign start_ok     = start_i && (state_q == StIdle || state_q == StDone);
    assign count_over   = 32'(word_count_i) > MEMORY_DEPTH;
    assign launch_state = (word_count_i == 16'd0 || count_over) ? StDone : StCollect;
    assign pack_accept  = (state_q == StCollect) && byte_valid_i;

    byte_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_ok),
        .accept_i(pack_accept),
        .byte_i  (byte_i),
        .word_o  (mem_data_o),
        .full_o  (pack_full)
    );

    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        busy_o       = 1'b1;
        cpu_hold_o   = 1'b1;
        done_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) state_d = launch_state;
            end
            StCollect: begin
                byte_ready_o = 1'b1;
                if (pack_full) state_d = StWrite;
            end
            StWrite: begin
                mem_we_o = 1'b1;
                if (remaining_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StCollect;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) state_d = StDone;
            end
`endif
            StDone: begin
                busy_o     = 1'b0;
                cpu_hold_o = 1'b0;
                done_o     = 1'b1;
                if (start_i) state_d = launch_state;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else if (start_ok) begin
            sum_q <= 8'd0;
        end else if (pack_accept) begin
            sum_q <= sum_q + byte_i;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= 16'd0;
            addr_q      <= BASE_ADDR;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                remaining_q <= word_count_i;
                addr_q      <= BASE_ADDR;
                error_q     <= count_over;
            end else if (state_q == StWrite) begin
                remaining_q <= remaining_q - 16'd1;
                addr_q      <= addr_q + DATA_WIDTH'(4);
            end
`ifdef LOADER_CHECKSUM_EN
            else if (state_q == StCheck && byte_valid_i && byte_i != sum_q) begin
                error_q <= 1'b1;
            end
`endif
        end
    end

    assign mem_addr_o = addr_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader against a transaction-level model, plus directed loads
// with literal expectations. Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_program_loader;

    localparam int unsigned Depth = 32;
    localparam logic [31:0] Base  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] word_count_i = 16'd0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o;
    logic [31:0] mem_addr_o, mem_data_o;

    program_loader #(
        .MEMORY_DEPTH(Depth),
        .DATA_WIDTH  (32),
        .BASE_ADDR   (Base)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .word_count_i(word_count_i),
        .byte_i      (byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .cpu_hold_o  (cpu_hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: what a load must look like from the outside.
    bit         m_busy, m_done, m_err, m_wr, m_chk;
    int         m_left;
    logic [31:0] m_addr;
    logic [7:0] m_sum;
    logic [7:0] m_bq[$];

    logic [31:0] dut_wa[$];
    logic [31:0] dut_wd[$];
    logic [7:0]  feed_q[$];

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_wr = 0; m_chk = 0;
        m_left = 0; m_addr = Base; m_sum = 0; m_bq.delete();
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (start_i) begin
                m_addr = Base; m_sum = 0; m_bq.delete(); m_wr = 0; m_chk = 0;
                if (word_count_i == 0) begin
                    m_done = 1; m_err = 0;
                end else if (int'(word_count_i) > Depth) begin
                    m_done = 1; m_err = 1;
                end else begin
                    m_busy = 1; m_done = 0; m_err = 0; m_left = int'(word_count_i);
                end
            end
        end else if (m_wr) begin
            m_wr = 0;
            m_addr = m_addr + 32'd4;
            m_left--;
            m_bq.delete();
            if (m_left == 0) begin
`ifdef LOADER_CHECKSUM_EN
                m_chk = 1;
`else
                m_busy = 0; m_done = 1;
`endif
            end
        end else if (m_chk) begin
            if (byte_valid_i) begin
                m_err = (byte_i != m_sum);
                m_chk = 0; m_busy = 0; m_done = 1;
            end
        end else if (byte_valid_i) begin
            m_bq.push_back(byte_i);
            m_sum = m_sum + byte_i;
            if (m_bq.size() == 4) m_wr = 1;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model_reset();
            check("reset_flags", {byte_ready_o, mem_we_o, busy_o, done_o, cpu_hold_o, error_o},
                  6'b000010);
            check("reset_addr", mem_addr_o, Base);
            check("reset_data", mem_data_o, 32'd0);
        end else begin
            check("flags", {byte_ready_o, mem_we_o, busy_o, done_o, cpu_hold_o, error_o},
                  {m_busy && !m_wr, m_wr, m_busy, m_done, !m_done, m_err});
            if (m_wr && mem_we_o) begin
                check("wr_addr", mem_addr_o, m_addr);
                check("wr_data", mem_data_o, {m_bq[3], m_bq[2], m_bq[1], m_bq[0]});
            end
            if (mem_we_o) begin
                dut_wa.push_back(mem_addr_o);
                dut_wd.push_back(mem_data_o);
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_sum(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'd0;
        foreach (feed_q[i]) s = s + feed_q[i];
        feed_q.push_back(corrupt ? s + 8'd1 : s);
`else
        if (corrupt) feed_q = feed_q;
`endif
    endtask

    // mode 0: always valid, 1: valid one cycle in three, 2: random
    task automatic run_load(input int cnt, input int mode, input bit noise, output int cyc);
        bit took;
        int budget;
        budget = 60 + cnt * 4 * 6;
        start_i = 1'b1;
        word_count_i = 16'(cnt);
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (!done_o && cyc < budget) begin
            byte_valid_i = (feed_q.size() > 0) &&
                ((mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1)));
            byte_i = byte_valid_i ? feed_q[0] : 8'($urandom);
            start_i = noise && ($urandom_range(0, 15) == 0);
            word_count_i = 16'($urandom);
            took = byte_valid_i && byte_ready_o;
            tick();
            if (took) void'(feed_q.pop_front());
            cyc++;
        end
        byte_valid_i = 1'b0;
        start_i = 1'b0;
        check("load_done", done_o, 1'b1);
    endtask

    task automatic clear_log();
        dut_wa.delete();
        dut_wd.delete();
    endtask

    int cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // two-word load
        clear_log();
        feed_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        add_sum(0);
        run_load(2, 0, 0, cyc);
        check("two_word_count", dut_wa.size(), 2);
        check("two_word_a0", dut_wa.size() > 0 ? dut_wa[0] : 32'hx, 32'h0040_0000);
        check("two_word_d0", dut_wd.size() > 0 ? dut_wd[0] : 32'hx, 32'h0000_0513);
        check("two_word_a1", dut_wa.size() > 1 ? dut_wa[1] : 32'hx, 32'h0040_0004);
        check("two_word_d1", dut_wd.size() > 1 ? dut_wd[1] : 32'hx, 32'h0010_0093);
        check("two_word_err", error_o, 1'b0);

        // zero words
        clear_log();
        feed_q.delete();
        run_load(0, 0, 0, cyc);
        check("zero_latency", cyc, 0);
        check("zero_err", error_o, 1'b0);
        check("zero_writes", dut_wa.size(), 0);

        // oversize request
        clear_log();
        run_load(33, 0, 0, cyc);
        check("over_latency", cyc, 0);
        check("over_err", error_o, 1'b1);
        check("over_writes", dut_wa.size(), 0);

        // sparse valid
        clear_log();
        feed_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        add_sum(0);
        run_load(1, 1, 0, cyc);
        check("sparse_count", dut_wd.size(), 1);
        check("sparse_data", dut_wd.size() > 0 ? dut_wd[0] : 32'hx, 32'hDDCC_BBAA);
        check("sparse_leftover", feed_q.size(), 0);

`ifdef LOADER_CHECKSUM_EN
        feed_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_load(1, 0, 0, cyc);
        check("csum_good_err", error_o, 1'b0);
        feed_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_load(1, 0, 0, cyc);
        check("csum_bad_err", error_o, 1'b1);
`endif

        // reset after two bytes of word 0
        clear_log();
        start_i = 1'b1;
        word_count_i = 16'd2;
        tick();
        start_i = 1'b0;
        byte_valid_i = 1'b1;
        byte_i = 8'h13;
        tick();
        byte_i = 8'h05;
        tick();
        byte_valid_i = 1'b0;
        reset = 1'b1;
        #2;
        check("abort_flags", {byte_ready_o, mem_we_o, busy_o, done_o, cpu_hold_o, error_o},
              6'b000010);
        check("abort_data", mem_data_o, 32'd0);
        check("abort_addr", mem_addr_o, Base);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_writes", dut_wa.size(), 0);
        feed_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        add_sum(0);
        run_load(2, 0, 0, cyc);
        check("reload_d0", dut_wd.size() > 0 ? dut_wd[0] : 32'hx, 32'h0000_0513);
        check("reload_d1", dut_wd.size() > 1 ? dut_wd[1] : 32'hx, 32'h0010_0093);

        // randomised loads, with stray starts and stray valids between loads
        for (int t = 0; t < 40; t++) begin
            int cnt;
            int sel;
            sel = $urandom_range(0, 9);
            cnt = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(30, 34) : $urandom_range(1, 6);
            feed_q.delete();
            if (cnt > 0 && cnt <= Depth) begin
                for (int i = 0; i < cnt * 4; i++) feed_q.push_back(8'($urandom));
                add_sum(1'($urandom_range(0, 1)));
            end
            run_load(cnt, $urandom_range(0, 2), 1, cyc);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                byte_valid_i = 1'($urandom_range(0, 1));
                byte_i = 8'($urandom);
                tick();
            end
            byte_valid_i = 1'b0;
        end

        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
